// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start / WIDTH data bits (LSB first) / optional parity / stop,
// delivered as a parallel word through a valid/ready holding register.
module serial_frame_rx #(
  parameter int WIDTH      = 3,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic           ODD_BIT  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               parity_bad_q, parity_bad_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               parity_err_q, parity_err_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
  logic               good_s;

  // Nonzero result means the received parity disagrees with the selected sense.
  function automatic logic calc_parity(input logic [WIDTH-1:0] data, input logic par_bit);
    return (^data) ^ par_bit ^ ODD_BIT;
  endfunction

  // Frame FSM: every transition is qualified by bit_valid.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    parity_bad_d = parity_bad_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    good_s       = 1'b0;
    if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_d      = DATA;
            cnt_d        = '0;
            parity_bad_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d[cnt_q] = serial_in;
          cnt_d          = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end
        PARITY: begin
          parity_bad_d = calc_parity(shift_q, serial_in);
          state_d      = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit masks any parity failure.
          if (!serial_in) begin
            frame_err_d = 1'b1;
          end else if (parity_bad_q) begin
            parity_err_d = 1'b1;
          end else begin
            good_s = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Holding register and handshake; a good frame may land on the same edge as a transfer.
  always_comb begin
    data_d      = data_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (good_s) begin
      if (!out_valid_q || out_ready) begin
        data_d      = shift_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      data_d = data_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      parity_bad_q <= 1'b0;
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      parity_bad_q <= parity_bad_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign parallel_out = data_q;
  assign out_valid    = out_valid_q;
  assign frame_err    = frame_err_q;
  assign parity_err   = parity_err_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=3, even parity); outputs sampled 1 time unit after each rising edge.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       serial_in;
  logic       out_ready;
  logic [2:0] parallel_out;
  logic       out_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  serial_frame_rx #(.WIDTH(3), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .serial_in(serial_in),
    .out_ready(out_ready), .parallel_out(parallel_out), .out_valid(out_valid),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    serial_in = b;
    tick();
    bit_valid = 1'b0;
    serial_in = 1'b1;
  endtask

  // Frame order: start, d[0], d[1], d[2], parity, stop. Returns in the cycle after the stop edge.
  task automatic send_frame(input logic [2:0] d, input logic p, input logic stop,
                            input int max_gap, input logic rdy_stop);
    logic [5:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (i == 5 && rdy_stop) out_ready = 1'b1;
      send_bit(bits[i]);
      if (i < 5) repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (out_valid !== 1'b0) begin $display("FAIL drain_valid got %b want 0", out_valid); err_cnt++; end vec_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; bit_valid = 1'b0; serial_in = 1'b1; out_ready = 1'b0;
    tick(); tick();
    if (parallel_out !== 3'b000) begin $display("FAIL rst_data got %b want 000", parallel_out); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b0) begin $display("FAIL rst_valid got %b want 0", out_valid); err_cnt++; end vec_cnt++;
    if (frame_err !== 1'b0) begin $display("FAIL rst_frame_err got %b want 0", frame_err); err_cnt++; end vec_cnt++;
    if (parity_err !== 1'b0) begin $display("FAIL rst_parity_err got %b want 0", parity_err); err_cnt++; end vec_cnt++;
    if (overrun !== 1'b0) begin $display("FAIL rst_overrun got %b want 0", overrun); err_cnt++; end vec_cnt++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy got %b want 0", busy); err_cnt++; end vec_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    send_bit(1'b0);
    if (busy !== 1'b1) begin $display("FAIL good_busy_rise got %b want 1", busy); err_cnt++; end vec_cnt++;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    if (out_valid !== 1'b0) begin $display("FAIL good_valid_early got %b want 0", out_valid); err_cnt++; end vec_cnt++;
    send_bit(1'b1);
    if (parallel_out !== 3'b101) begin $display("FAIL good_data got %b want 101", parallel_out); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b1) begin $display("FAIL good_valid got %b want 1", out_valid); err_cnt++; end vec_cnt++;
    if (busy !== 1'b0) begin $display("FAIL good_busy_fall got %b want 0", busy); err_cnt++; end vec_cnt++;
    if ({frame_err, parity_err, overrun} !== 3'b000) begin $display("FAIL good_pulses got %b want 000", {frame_err, parity_err, overrun}); err_cnt++; end vec_cnt++;
    repeat (4) tick();
    if (out_valid !== 1'b1) begin $display("FAIL good_hold_valid got %b want 1", out_valid); err_cnt++; end vec_cnt++;
    if (parallel_out !== 3'b101) begin $display("FAIL good_hold_data got %b want 101", parallel_out); err_cnt++; end vec_cnt++;
    drain();
  endtask

  task automatic test_parity_err();
    send_frame(3'b011, 1'b1, 1'b1, 0, 1'b0);
    if (parity_err !== 1'b1) begin $display("FAIL par_pulse got %b want 1", parity_err); err_cnt++; end vec_cnt++;
    if (frame_err !== 1'b0) begin $display("FAIL par_frame_err got %b want 0", frame_err); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b0) begin $display("FAIL par_valid got %b want 0", out_valid); err_cnt++; end vec_cnt++;
    tick();
    if (parity_err !== 1'b0) begin $display("FAIL par_pulse_len got %b want 0", parity_err); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b0) begin $display("FAIL par_valid_later got %b want 0", out_valid); err_cnt++; end vec_cnt++;
  endtask

  task automatic test_frame_err();
    send_frame(3'b100, 1'b1, 1'b0, 0, 1'b0);
    if (frame_err !== 1'b1) begin $display("FAIL frm_pulse got %b want 1", frame_err); err_cnt++; end vec_cnt++;
    if (parity_err !== 1'b0) begin $display("FAIL frm_parity_err got %b want 0", parity_err); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b0) begin $display("FAIL frm_valid got %b want 0", out_valid); err_cnt++; end vec_cnt++;
    tick();
    if (frame_err !== 1'b0) begin $display("FAIL frm_pulse_len got %b want 0", frame_err); err_cnt++; end vec_cnt++;
  endtask

  task automatic test_overrun();
    send_frame(3'b101, 1'b0, 1'b1, 0, 1'b0);
    send_frame(3'b010, 1'b1, 1'b1, 0, 1'b0);
    if (overrun !== 1'b1) begin $display("FAIL ovr_pulse got %b want 1", overrun); err_cnt++; end vec_cnt++;
    if (parallel_out !== 3'b101) begin $display("FAIL ovr_data got %b want 101", parallel_out); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b1) begin $display("FAIL ovr_valid got %b want 1", out_valid); err_cnt++; end vec_cnt++;
    tick();
    if (overrun !== 1'b0) begin $display("FAIL ovr_pulse_len got %b want 0", overrun); err_cnt++; end vec_cnt++;
    send_frame(3'b010, 1'b1, 1'b1, 0, 1'b1);
    out_ready = 1'b0;
    if (parallel_out !== 3'b010) begin $display("FAIL acc_data got %b want 010", parallel_out); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b1) begin $display("FAIL acc_valid got %b want 1", out_valid); err_cnt++; end vec_cnt++;
    if (overrun !== 1'b0) begin $display("FAIL acc_overrun got %b want 0", overrun); err_cnt++; end vec_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_frame(3'b110, 1'b0, 1'b1, 0, 1'b1);
    if (parallel_out !== 3'b110) begin $display("FAIL b2b_data1 got %b want 110", parallel_out); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b1) begin $display("FAIL b2b_valid1 got %b want 1", out_valid); err_cnt++; end vec_cnt++;
    send_frame(3'b001, 1'b1, 1'b1, 0, 1'b1);
    out_ready = 1'b0;
    if (parallel_out !== 3'b001) begin $display("FAIL b2b_data2 got %b want 001", parallel_out); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b1) begin $display("FAIL b2b_valid2 got %b want 1", out_valid); err_cnt++; end vec_cnt++;
    if (overrun !== 1'b0) begin $display("FAIL b2b_overrun got %b want 0", overrun); err_cnt++; end vec_cnt++;
    drain();
  endtask

  task automatic test_gapped();
    for (int k = 0; k < 3; k++) begin
      send_frame(3'b101, 1'b0, 1'b1, 5, 1'b0);
      if (parallel_out !== 3'b101) begin $display("FAIL gap_data[%0d] got %b want 101", k, parallel_out); err_cnt++; end vec_cnt++;
      if (out_valid !== 1'b1) begin $display("FAIL gap_valid[%0d] got %b want 1", k, out_valid); err_cnt++; end vec_cnt++;
      if ({frame_err, parity_err, overrun} !== 3'b000) begin $display("FAIL gap_pulses[%0d] got %b want 000", k, {frame_err, parity_err, overrun}); err_cnt++; end vec_cnt++;
      drain();
    end
  endtask

  task automatic test_reset_abort();
    send_frame(3'b010, 1'b1, 1'b1, 0, 1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    #2;
    reset = 1'b0;
    #1;
    if (busy !== 1'b0) begin $display("FAIL abort_busy got %b want 0", busy); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b0) begin $display("FAIL abort_valid got %b want 0", out_valid); err_cnt++; end vec_cnt++;
    tick();
    reset = 1'b1;
    tick();
    if ({frame_err, parity_err, overrun} !== 3'b000) begin $display("FAIL abort_pulses got %b want 000", {frame_err, parity_err, overrun}); err_cnt++; end vec_cnt++;
    send_frame(3'b011, 1'b0, 1'b1, 0, 1'b0);
    if (parallel_out !== 3'b011) begin $display("FAIL abort_next_data got %b want 011", parallel_out); err_cnt++; end vec_cnt++;
    if (out_valid !== 1'b1) begin $display("FAIL abort_next_valid got %b want 1", out_valid); err_cnt++; end vec_cnt++;
    drain();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      send_bit(1'b1);
      if ({busy, out_valid, frame_err, parity_err, overrun} !== 5'b00000) begin
        $display("FAIL idle[%0d] got %b want 00000", c, {busy, out_valid, frame_err, parity_err, overrun}); err_cnt++;
      end
      vec_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_gapped();
    test_reset_abort();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
